// File: rtl/placement_pkg.sv
// Shared widths, FSM state encoding and helpers for the placement sequencer.
// Combinational content only: no latency, no flow control.
package placement_pkg;

  localparam int HEIGHT_W = 5;
  localparam int WIDTH_W  = 5;
  localparam int IDX_W    = 8;
  localparam int STRIKE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  function automatic logic is_zero_size(input logic [HEIGHT_W-1:0] h,
                                        input logic [WIDTH_W-1:0]  w);
    return (h == '0) || (w == '0);
  endfunction

endpackage

// File: rtl/placement_sequencer_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant plus encoded index, search starts at ptr_i.
// Purely combinational; a requester stalls simply by not being granted.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             vld_o
);

  always_comb begin
    int  k;
    logic found;
    k       = 0;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!found && req_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = SEL_W'(k);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/placement_sequencer.sv
// Issues one arbitrated (height, width) request into the placement pipeline and returns the result.
// Response PIPE_LAT+2 cycles after accept (1 for zero-size); holds rsp_* until rsp_ready_i, no new accepts meanwhile.
module placement_sequencer
  import placement_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PIPE_LAT   = 3,
  parameter int STRIKE_MAX = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [HEIGHT_W*N_REQ-1:0]   req_height_i,
  input  logic [WIDTH_W*N_REQ-1:0]    req_width_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        pl_start_o,
  output logic [HEIGHT_W-1:0]         pl_height_o,
  output logic [WIDTH_W-1:0]          pl_width_o,
  input  logic [IDX_W-1:0]            pl_index_x_i,
  input  logic [IDX_W-1:0]            pl_index_y_i,
  input  logic [STRIKE_W-1:0]         pl_strike_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [$clog2(N_REQ)-1:0]    rsp_id_o,
  output logic [IDX_W-1:0]            rsp_index_x_o,
  output logic [IDX_W-1:0]            rsp_index_y_o,
  output logic [STRIKE_W-1:0]         rsp_strike_o,
  output logic                        rsp_fail_o,
  output logic                        busy_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [STRIKE_W-1:0] STRIKE_LIM = STRIKE_W'(STRIKE_MAX);

  seq_state_t           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 pl_start_q, pl_start_d;
  logic [HEIGHT_W-1:0]  pl_height_q, pl_height_d;
  logic [WIDTH_W-1:0]   pl_width_q, pl_width_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [IDX_W-1:0]     rsp_x_q, rsp_x_d;
  logic [IDX_W-1:0]     rsp_y_q, rsp_y_d;
  logic [STRIKE_W-1:0]  rsp_strike_q, rsp_strike_d;
  logic                 rsp_fail_q, rsp_fail_d;

  logic [N_REQ-1:0]     gnt;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_vld;
  logic [HEIGHT_W-1:0]  sel_height;
  logic [WIDTH_W-1:0]   sel_width;

  rr_arbiter #(.N(N_REQ), .SEL_W(ID_W)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx),
    .vld_o   (gnt_vld)
  );

  assign sel_height = req_height_i[int'(gnt_idx)*HEIGHT_W +: HEIGHT_W];
  assign sel_width  = req_width_i[int'(gnt_idx)*WIDTH_W +: WIDTH_W];

  // Gated by rst_i so the grant cannot leak out while reset is held.
  assign req_ready_o   = (state_q == IDLE && rst_i) ? gnt : '0;
  assign pl_start_o    = pl_start_q;
  assign pl_height_o   = pl_height_q;
  assign pl_width_o    = pl_width_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_index_x_o = rsp_x_q;
  assign rsp_index_y_o = rsp_y_q;
  assign rsp_strike_o  = rsp_strike_q;
  assign rsp_fail_o    = rsp_fail_q;
  assign busy_o        = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    wait_cnt_d   = wait_cnt_q;
    pl_start_d   = 1'b0;
    pl_height_d  = pl_height_q;
    pl_width_d   = pl_width_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_x_d      = rsp_x_q;
    rsp_y_d      = rsp_y_q;
    rsp_strike_d = rsp_strike_q;
    rsp_fail_d   = rsp_fail_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          rsp_id_d = gnt_idx;
          if (is_zero_size(sel_height, sel_width)) begin
            // Nothing to place: answer immediately without touching the pipeline.
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_x_d      = '0;
            rsp_y_d      = '0;
            rsp_strike_d = '0;
            rsp_fail_d   = 1'b1;
          end else begin
            state_d     = ISSUE;
            pl_start_d  = 1'b1;
            pl_height_d = sel_height;
            pl_width_d  = sel_width;
          end
        end
      end
      ISSUE: begin
        wait_cnt_d = CNT_W'(PIPE_LAT - 1);
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          rsp_x_d      = pl_index_x_i;
          rsp_y_d      = pl_index_y_i;
          rsp_strike_d = pl_strike_i;
          rsp_fail_d   = (pl_strike_i >= STRIKE_LIM);
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      wait_cnt_q   <= '0;
      pl_start_q   <= 1'b0;
      pl_height_q  <= '0;
      pl_width_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      rsp_strike_q <= '0;
      rsp_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      wait_cnt_q   <= wait_cnt_d;
      pl_start_q   <= pl_start_d;
      pl_height_q  <= pl_height_d;
      pl_width_q   <= pl_width_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_x_q      <= rsp_x_d;
      rsp_y_q      <= rsp_y_d;
      rsp_strike_q <= rsp_strike_d;
      rsp_fail_q   <= rsp_fail_d;
    end
  end

endmodule

// File: tb/tb_placement_sequencer.sv
// Bench for placement_sequencer: directed scenarios plus a randomized run against a transaction-level model.
module tb_placement_sequencer;
  import placement_pkg::*;

  localparam int N_REQ      = 4;
  localparam int PIPE_LAT   = 3;
  localparam int STRIKE_MAX = 8;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_REQ-1:0]          req_valid;
  logic [5*N_REQ-1:0]        req_height;
  logic [5*N_REQ-1:0]        req_width;
  logic [N_REQ-1:0]          req_ready;
  logic                      pl_start;
  logic [4:0]                pl_height, pl_width;
  logic [7:0]                pl_x, pl_y;
  logic [3:0]                pl_s;
  logic                      rsp_valid, rsp_ready;
  logic [1:0]                rsp_id;
  logic [7:0]                rsp_x, rsp_y;
  logic [3:0]                rsp_s;
  logic                      rsp_fail, busy;

  always #5 clk = ~clk;

  placement_sequencer #(.N_REQ(N_REQ), .PIPE_LAT(PIPE_LAT), .STRIKE_MAX(STRIKE_MAX)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_height_i(req_height), .req_width_i(req_width),
    .req_ready_o(req_ready),
    .pl_start_o(pl_start), .pl_height_o(pl_height), .pl_width_o(pl_width),
    .pl_index_x_i(pl_x), .pl_index_y_i(pl_y), .pl_strike_i(pl_s),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_index_x_o(rsp_x), .rsp_index_y_o(rsp_y), .rsp_strike_o(rsp_s),
    .rsp_fail_o(rsp_fail), .busy_o(busy)
  );

  int checks = 0, errors = 0, cyc = 0;
  int start_cnt = 0, pend_due = 0;
  bit pend_act = 0;
  int force_x = -1, force_y = -1, force_s = -1;
  logic [7:0] pend_x, pend_y, last_x, last_y;
  logic [3:0] pend_s, last_s;
  int ptr_m = 0;

  function automatic int rr_pick(input logic [N_REQ-1:0] m, input int p);
    for (int i = 0; i < N_REQ; i++) begin
      if (m[(p + i) % N_REQ]) return (p + i) % N_REQ;
    end
    return -1;
  endfunction

  // Advance one cycle; pipeline stub returns its result exactly PIPE_LAT cycles after a start, garbage otherwise.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (pend_act && cyc == pend_due) begin
      pl_x = pend_x; pl_y = pend_y; pl_s = pend_s; pend_act = 0;
    end else begin
      pl_x = 8'($urandom); pl_y = 8'($urandom); pl_s = 4'($urandom);
    end
    if (pl_start === 1'b1) begin
      start_cnt++;
      pend_act = 1; pend_due = cyc + PIPE_LAT;
      pend_x = (force_x >= 0) ? 8'(force_x) : 8'($urandom);
      pend_y = (force_y >= 0) ? 8'(force_y) : 8'($urandom);
      pend_s = (force_s >= 0) ? 4'(force_s) : 4'($urandom);
      last_x = pend_x; last_y = pend_y; last_s = pend_s;
    end
  endtask

  task automatic set_req(input int k, input logic [4:0] h, input logic [4:0] w);
    req_valid[k] = 1'b1;
    req_height[5*k +: 5] = h;
    req_width[5*k +: 5] = w;
  endtask

  task automatic drain();
    int c;
    req_valid = '0; rsp_ready = 1'b1;
    c = 0;
    while (busy === 1'b1 && c < 50) begin cycle(); c++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_timeout busy=%b expected 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_height = 20'hFFFFF; req_width = 20'hFFFFF; rsp_ready = 1'b0;
    pl_x = '0; pl_y = '0; pl_s = '0;
    repeat (3) cycle();
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    checks++; if ({pl_start, pl_height, pl_width} !== '0) begin errors++; $display("FAIL reset_pl got %b/%0d/%0d exp 0", pl_start, pl_height, pl_width); end
    checks++; if ({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail} !== '0) begin errors++; $display("FAIL reset_rsp got v=%b id=%0d x=%0d y=%0d s=%0d f=%b exp 0", rsp_valid, rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    req_valid = '0; rst_n = 1'b1; ptr_m = 0;
    cycle();
  endtask

  task automatic test_single();
    force_x = 5; force_y = 2; force_s = 1; rsp_ready = 1'b1;
    set_req(0, 5'd3, 5'd4);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", req_ready); end
    cycle(); req_valid = '0; #1;
    checks++; if ({pl_start, pl_height, pl_width} !== {1'b1, 5'd3, 5'd4}) begin errors++; $display("FAIL single_issue got %b/%0d/%0d exp 1/3/4", pl_start, pl_height, pl_width); end
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_busy got busy=%b rv=%b exp 1/0", busy, rsp_valid); end
    for (int i = 2; i <= PIPE_LAT + 1; i++) begin
      cycle();
      checks++; if (pl_start !== 1'b0 || rsp_valid !== 1'b0 || pl_height !== 5'd3) begin errors++; $display("FAIL single_wait cyc+%0d got start=%b rv=%b h=%0d exp 0/0/3", i, pl_start, rsp_valid, pl_height); end
    end
    cycle();
    checks++; if ({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail} !== {1'b1, 2'd0, 8'd5, 8'd2, 4'd1, 1'b0}) begin errors++; $display("FAIL single_rsp got v=%b id=%0d x=%0d y=%0d s=%0d f=%b exp 1/0/5/2/1/0", rsp_valid, rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail); end
    cycle();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got rv=%b busy=%b exp 0/0", rsp_valid, busy); end
    force_x = -1; force_y = -1; force_s = -1; ptr_m = 1;
  endtask

  task automatic test_round_robin();
    int gid[5], gcy[5], n;
    rst_n = 1'b0; cycle(); rst_n = 1'b1; ptr_m = 0;
    for (int k = 0; k < N_REQ; k++) set_req(k, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
    rsp_ready = 1'b1; n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      #1;
      if (req_ready !== '0) begin
        checks++; if (!$onehot(req_ready)) begin errors++; $display("FAIL rr_onehot got %b exp one-hot", req_ready); end
        gid[n] = -1;
        for (int k = 0; k < N_REQ; k++) if (req_ready[k]) gid[n] = k;
        gcy[n] = cyc; n++;
      end
      cycle();
    end
    checks++; if (n != 5) begin errors++; $display("FAIL rr_count got %0d grants exp 5", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (gid[i] != i % N_REQ) begin errors++; $display("FAIL rr_order grant %0d got id %0d exp %0d", i, gid[i], i % N_REQ); end
      if (i > 0) begin
        checks++; if (gcy[i] - gcy[i-1] != PIPE_LAT + 3) begin errors++; $display("FAIL rr_spacing grant %0d got %0d exp %0d", i, gcy[i] - gcy[i-1], PIPE_LAT + 3); end
      end
    end
    drain(); ptr_m = 1;
  endtask

  task automatic test_strike();
    int vals[4] = '{8, 7, 15, 0};
    int k;
    for (int t = 0; t < 4; t++) begin
      force_s = vals[t]; k = $urandom_range(0, N_REQ - 1);
      set_req(k, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
      rsp_ready = 1'b1; #1;
      checks++; if (req_ready !== 4'(1 << k)) begin errors++; $display("FAIL strike_grant got %b exp %b", req_ready, 4'(1 << k)); end
      cycle(); req_valid = '0;
      for (int c = 0; c < 20 && rsp_valid !== 1'b1; c++) cycle();
      checks++; if ({rsp_valid, rsp_id, rsp_s, rsp_fail} !== {1'b1, 2'(k), 4'(vals[t]), vals[t] >= STRIKE_MAX}) begin errors++; $display("FAIL strike_%0d got v=%b id=%0d s=%0d f=%b exp 1/%0d/%0d/%0d", vals[t], rsp_valid, rsp_id, rsp_s, rsp_fail, k, vals[t], vals[t] >= STRIKE_MAX); end
      cycle(); ptr_m = (k + 1) % N_REQ;
    end
    force_s = -1;
  endtask

  task automatic test_zero_size();
    int sc;
    for (int t = 0; t < 2; t++) begin
      sc = start_cnt;
      if (t == 0) set_req(2, 5'd9, 5'd0); else set_req(2, 5'd0, 5'd17);
      rsp_ready = 1'b1; #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL zero_grant got %b exp 0100", req_ready); end
      cycle(); req_valid = '0; #1;
      checks++; if ({rsp_valid, rsp_id, rsp_fail, rsp_x, rsp_y, rsp_s} !== {1'b1, 2'd2, 1'b1, 20'd0}) begin errors++; $display("FAIL zero_rsp got v=%b id=%0d f=%b x=%0d y=%0d s=%0d exp 1/2/1/0/0/0", rsp_valid, rsp_id, rsp_fail, rsp_x, rsp_y, rsp_s); end
      checks++; if (pl_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_state got start=%b busy=%b exp 0/1", pl_start, busy); end
      repeat (PIPE_LAT + 2) cycle();
      checks++; if (start_cnt != sc || busy !== 1'b0) begin errors++; $display("FAIL zero_nostart got starts=%0d busy=%b exp %0d/0", start_cnt - sc, busy, 0); end
    end
    ptr_m = 3;
  endtask

  task automatic test_backpressure();
    logic fail_exp;
    set_req(3, 5'd11, 5'd6); rsp_ready = 1'b0; #1;
    cycle(); req_valid = '0;
    for (int c = 0; c < 20 && rsp_valid !== 1'b1; c++) cycle();
    fail_exp = (last_s >= 4'(STRIKE_MAX));
    for (int k = 0; k < N_REQ; k++) set_req(k, 5'd1, 5'd1);
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail, req_ready} !== {1'b1, 2'd3, last_x, last_y, last_s, fail_exp, 4'b0}) begin errors++; $display("FAIL bp_hold %0d got v=%b id=%0d x=%0d y=%0d s=%0d f=%b rdy=%b exp 1/3/%0d/%0d/%0d/%b/0000", i, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail, req_ready, last_x, last_y, last_s, fail_exp); end
      cycle();
    end
    rsp_ready = 1'b1;
    cycle(); #1;
    checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_next_grant got rdy=%b rv=%b exp 0001/0", req_ready, rsp_valid); end
    req_valid = '0; ptr_m = 0;
    cycle();
  endtask

  task automatic test_reset_wait();
    int sc;
    req_valid = '0; set_req(1, 5'd7, 5'd7); rsp_ready = 1'b1; #1;
    cycle(); req_valid = '0;
    cycle();
    rst_n = 1'b0; req_valid = 4'hF; #1;
    checks++; if ({req_ready, pl_start, pl_height, pl_width, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail, busy} !== '0) begin errors++; $display("FAIL rstwait_async got rdy=%b st=%b h=%0d w=%0d rv=%b busy=%b exp all 0", req_ready, pl_start, pl_height, pl_width, rsp_valid, busy); end
    cycle(); #1;
    checks++; if ({req_ready, pl_start, pl_height, pl_width, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail, busy} !== '0) begin errors++; $display("FAIL rstwait_next got rdy=%b st=%b rv=%b busy=%b exp all 0", req_ready, pl_start, rsp_valid, busy); end
    rst_n = 1'b1; req_valid = '0; sc = start_cnt;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || pl_start !== 1'b0) begin errors++; $display("FAIL rstwait_stale %0d got rv=%b busy=%b st=%b exp 0/0/0", i, rsp_valid, busy, pl_start); end
    end
    req_valid = 4'hF; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstwait_first_grant got %b exp 0001", req_ready); end
    req_valid = '0; ptr_m = 0;
    cycle();
  endtask

  task automatic test_random();
    bit out = 0, ez = 0, exp_start, exp_rsp;
    int acc = 0, id = 0, g;
    logic [4:0] eh = '0, ew = '0;
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom) & 4'($urandom);
      for (int k = 0; k < N_REQ; k++) begin
        req_height[5*k +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        req_width[5*k +: 5]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_start = out && !ez && (cyc == acc + 1);
      checks++; if (pl_start !== exp_start) begin errors++; $display("FAIL rand_start cyc %0d got %b exp %b", cyc, pl_start, exp_start); end
      if (exp_start) begin
        checks++; if (pl_height !== eh || pl_width !== ew) begin errors++; $display("FAIL rand_hw got %0d/%0d exp %0d/%0d", pl_height, pl_width, eh, ew); end
      end
      exp_rsp = out && (cyc >= acc + (ez ? 1 : 2 + PIPE_LAT));
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rand_rsp_valid cyc %0d got %b exp %b", cyc, rsp_valid, exp_rsp); end
      if (exp_rsp) begin
        if (ez) begin
          checks++; if ({rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail} !== {2'(id), 20'd0, 1'b1}) begin errors++; $display("FAIL rand_zero_rsp got id=%0d x=%0d y=%0d s=%0d f=%b exp %0d/0/0/0/1", rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail, id); end
        end else begin
          checks++; if ({rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail} !== {2'(id), last_x, last_y, last_s, last_s >= 4'(STRIKE_MAX)}) begin errors++; $display("FAIL rand_rsp got id=%0d x=%0d y=%0d s=%0d f=%b exp %0d/%0d/%0d/%0d", rsp_id, rsp_x, rsp_y, rsp_s, rsp_fail, id, last_x, last_y, last_s); end
        end
      end
      checks++; if (busy !== (out && cyc > acc)) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", cyc, busy, out && cyc > acc); end
      if (!out) begin
        g = rr_pick(req_valid, ptr_m);
        checks++; if (req_ready !== ((g < 0) ? 4'b0 : 4'(1 << g))) begin errors++; $display("FAIL rand_grant cyc %0d got %b exp pick %0d", cyc, req_ready, g); end
        if (g >= 0) begin
          out = 1; acc = cyc; id = g; ptr_m = (g + 1) % N_REQ;
          eh = req_height[5*g +: 5]; ew = req_width[5*g +: 5];
          ez = (eh == 5'd0) || (ew == 5'd0);
        end
      end else begin
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rand_ready_busy cyc %0d got %b exp 0000", cyc, req_ready); end
        if (exp_rsp && rsp_ready) out = 0;
      end
      cycle();
    end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_strike();
    test_zero_size();
    test_backpressure();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
